// File: rtl/full_adder_df.sv
// -----------------------------------------------------------------------------
// full_adder_df
//   1-bit dataflow full adder with a clocked wrapper.
//   Combinational S/C are the primary outputs and react to x/y/z (or to the
//   internal carry flop in serial mode) without any clock involvement.
//   The wrapper keeps registered copies of S/C and an internal carry flop
//   that lets the cell add LSB-first serial operands one bit per clock.
//
// Parameters:
//   SERIAL_EN  1 = serial mode logic present; 0 = serial_mode treated as 0
//   CARRY_RST  reset / clear value of the internal carry flop (1 allows
//              serial subtraction with an inverted subtrahend)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   x, y         operand bits
//   z            carry-in bit used in parallel mode
//   serial_mode  1 = carry-in comes from carry_q instead of z
//   serial_clr   synchronous clear of carry_q to CARRY_RST (wins over mode)
//   S, C         combinational sum / carry-out
//   s_q, c_q     registered sum / carry-out (1 cycle latency)
//   carry_q      current internal carry flop value
// -----------------------------------------------------------------------------
module full_adder_df #(
  parameter bit SERIAL_EN = 1'b1,
  parameter bit CARRY_RST = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic serial_mode,
  input  logic serial_clr,
  output logic S,
  output logic C,
  output logic s_q,
  output logic c_q,
  output logic carry_q
);

  // Sum bit of a full adder: odd parity of the three inputs.
  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  // Carry bit of a full adder: majority of the three inputs.
  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (a & ci) | (b & ci);
  endfunction

  logic serial_act_s;
  logic cin_s;
  logic s_d;
  logic c_d;
  logic carry_d;

  // Carry-in selection, adder equations and next-state for the flops.
  always_comb begin
    serial_act_s = 1'b0;
    cin_s        = z;
    s_d          = 1'b0;
    c_d          = 1'b0;
    carry_d      = carry_q;

    serial_act_s = SERIAL_EN && serial_mode;

    if (serial_act_s) begin
      cin_s = carry_q;
    end else begin
      cin_s = z;
    end

    s_d = fa_sum(x, y, cin_s);
    c_d = fa_carry(x, y, cin_s);

    // Clear has priority; S/C this cycle still see the old carry_q.
    if (serial_clr) begin
      carry_d = CARRY_RST;
    end else if (serial_act_s) begin
      carry_d = c_d;
    end else begin
      carry_d = carry_q;
    end
  end

  assign S = s_d;
  assign C = c_d;

  // Registered sum/carry and the serial carry flop; reset aborts any serial add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 1'b0;
      c_q     <= 1'b0;
      carry_q <= CARRY_RST;
    end else begin
      s_q     <= s_d;
      c_q     <= c_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_full_adder_df.sv
// -----------------------------------------------------------------------------
// tb_full_adder_df
//   Self-checking bench for full_adder_df (SERIAL_EN=1, CARRY_RST=0).
//   The reference model treats the cell as arithmetic: {C,S} = x + y + cin,
//   and serial additions are checked against the integer sum of the operands.
// -----------------------------------------------------------------------------
module tb_full_adder_df;

  localparam bit CARRY_RST_P = 1'b0;

  logic clk;
  logic rst_n;
  logic x;
  logic y;
  logic z;
  logic serial_mode;
  logic serial_clr;
  logic S;
  logic C;
  logic s_q;
  logic c_q;
  logic carry_q;

  int tests_run;
  int tests_failed;

  full_adder_df #(
    .SERIAL_EN(1'b1),
    .CARRY_RST(CARRY_RST_P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .y(y),
    .z(z),
    .serial_mode(serial_mode),
    .serial_clr(serial_clr),
    .S(S),
    .C(C),
    .s_q(s_q),
    .c_q(c_q),
    .carry_q(carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, got %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Drive inputs on the falling edge, well away from the active edge.
  task automatic drive(input logic xi, input logic yi, input logic zi,
                       input logic mode, input logic clr);
    @(negedge clk);
    x = xi; y = yi; z = zi; serial_mode = mode; serial_clr = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    rst_n = 1'b0;
    x = 1'b1; y = 1'b0; z = 1'b0; serial_mode = 1'b1; serial_clr = 1'b0;
    #3;
    tests_run++;
    if ({s_q, c_q, carry_q} !== {1'b0, 1'b0, CARRY_RST_P}) begin
      tests_failed++;
      $display("FAIL reset_state: got s_q,c_q,carry_q=%b%b%b required 00%b",
               s_q, c_q, carry_q, CARRY_RST_P);
    end
    // Combinational path still works in reset, serial cin = CARRY_RST.
    exp = 2'(int'(x) + int'(y) + int'(CARRY_RST_P));
    tests_run++;
    if ({C, S} !== exp) begin
      tests_failed++;
      $display("FAIL reset_comb: got C,S=%b%b required %b", C, S, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    serial_mode = 1'b0;
  endtask

  task automatic test_parallel_sweep();
    logic [1:0] table_cs [8];
    logic [2:0] v;
    table_cs = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0], 1'b0, 1'b0);
      // Checked 6 time units after the last rising edge: no edge in between.
      tests_run++;
      if ({C, S} !== table_cs[i] || {C, S} !== 2'(int'(v[2]) + int'(v[1]) + int'(v[0]))) begin
        tests_failed++;
        $display("FAIL parallel_sweep xyz=%b: got C,S=%b%b required %b", v, C, S, table_cs[i]);
      end
    end
  endtask

  task automatic test_registered();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({s_q, c_q} !== 2'b01) begin
      tests_failed++;
      $display("FAIL registered_110: got s_q,c_q=%b%b required 01", s_q, c_q);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({s_q, c_q} !== 2'b10) begin
      tests_failed++;
      $display("FAIL registered_001: got s_q,c_q=%b%b required 10", s_q, c_q);
    end
  endtask

  task automatic test_random_mixed();
    logic m_carry;
    logic xi, yi, zi, mi, ci, cin;
    logic [1:0] exp;
    // Start from a known carry value.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    m_carry = CARRY_RST_P;
    for (int i = 0; i < 60; i++) begin
      xi = 1'($urandom); yi = 1'($urandom); zi = 1'($urandom);
      mi = 1'($urandom); ci = ($urandom_range(0, 7) == 0);
      drive(xi, yi, zi, mi, ci);
      cin = mi ? m_carry : zi;
      exp = 2'(int'(xi) + int'(yi) + int'(cin));
      tests_run++;
      if ({C, S} !== exp) begin
        tests_failed++;
        $display("FAIL random_comb[%0d]: got C,S=%b%b required %b", i, C, S, exp);
      end
      tick();
      if (ci) m_carry = CARRY_RST_P;
      else if (mi) m_carry = exp[1];
      tests_run++;
      if ({c_q, s_q, carry_q} !== {exp, m_carry}) begin
        tests_failed++;
        $display("FAIL random_reg[%0d]: got c_q,s_q,carry_q=%b%b%b required %b%b",
                 i, c_q, s_q, carry_q, exp, m_carry);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tests_run++;
    if ({s_q, carry_q} !== 2'b11) begin
      tests_failed++;
      $display("FAIL async_pre: got s_q,carry_q=%b%b required 11", s_q, carry_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({s_q, c_q, carry_q} !== {1'b0, 1'b0, CARRY_RST_P}) begin
      tests_failed++;
      $display("FAIL async_reset: got s_q,c_q,carry_q=%b%b%b required 00%b",
               s_q, c_q, carry_q, CARRY_RST_P);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_serial_add(input int a, input int b, input int nbits);
    int got;
    int want;
    want = a + b;
    got = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < nbits; i++) begin
      // z is randomised: it must be ignored in serial mode.
      drive(1'((a >> i) & 1), 1'((b >> i) & 1), 1'($urandom), 1'b1, 1'b0);
      got = got | (int'(S) << i);
      tick();
    end
    got = got | (int'(carry_q) << nbits);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL serial_add %0d+%0d: got %0d required %0d", a, b, got, want);
    end
  endtask

  task automatic test_serial_carry();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({C, S} !== 2'b10) begin
      tests_failed++;
      $display("FAIL serial_carry_comb: got C,S=%b%b required 10", C, S);
    end
    tick();
    tests_run++;
    if (carry_q !== 1'b1) begin
      tests_failed++;
      $display("FAIL serial_carry_flop: got carry_q=%b required 1", carry_q);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({C, S} !== 2'b01) begin
      tests_failed++;
      $display("FAIL serial_carry_next: got C,S=%b%b required 01", C, S);
    end
    tick();
  endtask

  task automatic test_clear_priority();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if ({carry_q, C, S} !== 3'b101) begin
      tests_failed++;
      $display("FAIL clear_prio_comb: got carry_q,C,S=%b%b%b required 101", carry_q, C, S);
    end
    tick();
    tests_run++;
    if ({carry_q, s_q} !== {CARRY_RST_P, 1'b1}) begin
      tests_failed++;
      $display("FAIL clear_prio_flop: got carry_q,s_q=%b%b required %b1",
               carry_q, s_q, CARRY_RST_P);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_parallel_sweep();
    test_registered();
    test_random_mixed();
    test_async_reset();
    test_serial_add(3, 5, 4);
    for (int k = 0; k < 8; k++) begin
      test_serial_add(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 8);
    end
    test_serial_carry();
    test_clear_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
